hdmi_link_sequencer: RTL

- Sequences HDMI-over-QSFP link bring-up.
- Debounces hot-plug detect (HPD), then issues an ordered list of I2C register writes to the NB7NQ621M redriver through a byte-level I2C master. It then asserts run to enable the TX video path.
- Tears the link down on HPD loss and retries configuration on NACK.
- Sits between the HPD/I2C pins and the HDMI output example logic, in the system clock domain.

---
 rtl/hdmi_link_sequencer.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/hdmi_link_sequencer.sv
// HDMI-over-QSFP link bring-up sequencer. It debounces HPD, sends the
// redriver configuration table through a byte-level I2C master, and then
// enables the TX path. A NACKed write restarts the sequence after a delay,
// and the block enters FAULT once the retry limit is used up.
module hdmi_link_sequencer #(
  parameter int unsigned DEBOUNCE_CYCLES    = 20_000_000,
  parameter int unsigned RETRY_DELAY_CYCLES = 2_000_000,
  parameter int unsigned RETRY_LIMIT        = 3,
  parameter int unsigned WRITE_COUNT        = 8,
  parameter logic [6:0]  DEVICE_ADDRESS     = 7'h5B
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        hpd,
  output logic [7:0]  table_index,
  input  logic [15:0] table_data,
  output logic        cmd_valid,
  input  logic        cmd_ready,
  output logic [6:0]  cmd_address,
  output logic [7:0]  cmd_register,
  output logic [7:0]  cmd_data,
  input  logic        rsp_valid,
  input  logic        rsp_nack,
  output logic        run,
  output logic        fault,
  output logic [1:0]  attempt
);

  localparam int unsigned DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int unsigned BO_W = (RETRY_DELAY_CYCLES > 1) ? $clog2(RETRY_DELAY_CYCLES) : 1;
  localparam logic [DB_W-1:0] DB_LAST    = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [BO_W-1:0] BO_LAST    = BO_W'(RETRY_DELAY_CYCLES - 1);
  localparam logic [7:0]      LAST_INDEX = 8'(WRITE_COUNT - 1);

  typedef enum logic [2:0] {
    ST_IDLE, ST_DEBOUNCE, ST_ISSUE, ST_WAIT, ST_BACKOFF, ST_RUNNING, ST_FAULT
  } state_t;

  state_t          state, state_d;
  logic [DB_W-1:0] db_cnt, db_cnt_d;
  logic [BO_W-1:0] bo_cnt, bo_cnt_d;
  logic [7:0]      index_d;
  logic [1:0]      attempt_d, attempt_inc;
  logic            is_last, last_d;
  logic            hpd_lost, lost_d;
  logic            load;

  assign attempt_inc = (attempt == 2'd3) ? attempt : attempt + 2'd1;

  // Next-state logic. table_index runs one step ahead. It advances when a
  // write is accepted, so table_data already holds the next entry when the
  // command fields are loaded on entry to ISSUE. is_last remembers whether
  // the outstanding write is the final one.
  always_comb begin
    state_d   = state;
    db_cnt_d  = db_cnt;
    bo_cnt_d  = bo_cnt;
    index_d   = table_index;
    attempt_d = attempt;
    last_d    = is_last;
    lost_d    = 1'b0;
    load      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (hpd) begin
          state_d  = ST_DEBOUNCE;
          db_cnt_d = '0;
        end
      end
      ST_DEBOUNCE: begin
        if (!hpd) begin
          state_d = ST_IDLE;
        end else if (db_cnt == DB_LAST) begin
          state_d   = ST_ISSUE;
          load      = 1'b1;
          attempt_d = attempt_inc;
        end else begin
          db_cnt_d = db_cnt + 1'b1;
        end
      end
      ST_ISSUE: begin
        if (cmd_valid && cmd_ready) begin
          state_d = ST_WAIT;
          last_d  = (table_index == LAST_INDEX);
          lost_d  = !hpd;
          if (table_index != LAST_INDEX) index_d = table_index + 8'd1;
        end else if (!hpd) begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        lost_d = hpd_lost || !hpd;
        if (rsp_valid) begin
          if (hpd_lost || !hpd) begin
            state_d = ST_IDLE;
          end else if (!rsp_nack) begin
            if (is_last) begin
              state_d = ST_RUNNING;
            end else begin
              state_d = ST_ISSUE;
              load    = 1'b1;
            end
          end else if ({30'd0, attempt} == RETRY_LIMIT) begin
            state_d = ST_FAULT;
          end else begin
            state_d  = ST_BACKOFF;
            bo_cnt_d = '0;
          end
        end
      end
      ST_BACKOFF: begin
        if (!hpd) begin
          state_d = ST_IDLE;
        end else if (bo_cnt == BO_LAST) begin
          state_d   = ST_ISSUE;
          load      = 1'b1;
          attempt_d = attempt_inc;
        end else begin
          bo_cnt_d = bo_cnt + 1'b1;
        end
      end
      ST_RUNNING: if (!hpd) state_d = ST_IDLE;
      ST_FAULT:   if (!hpd) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
    if (state_d inside {ST_IDLE, ST_DEBOUNCE, ST_BACKOFF}) index_d = '0;
    if (state_d == ST_IDLE) attempt_d = '0;
  end

  // State, counters and registered outputs, all cleared asynchronously.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state        <= ST_IDLE;
      db_cnt       <= '0;
      bo_cnt       <= '0;
      table_index  <= '0;
      attempt      <= '0;
      is_last      <= 1'b0;
      hpd_lost     <= 1'b0;
      cmd_valid    <= 1'b0;
      cmd_address  <= '0;
      cmd_register <= '0;
      cmd_data     <= '0;
      run          <= 1'b0;
      fault        <= 1'b0;
    end else begin
      state       <= state_d;
      db_cnt      <= db_cnt_d;
      bo_cnt      <= bo_cnt_d;
      table_index <= index_d;
      attempt     <= attempt_d;
      is_last     <= last_d;
      hpd_lost    <= lost_d;
      cmd_valid   <= (state_d == ST_ISSUE);
      run         <= (state == ST_RUNNING) && (state_d == ST_RUNNING);
      fault       <= (state_d == ST_FAULT);
      if (load) begin
        cmd_address  <= DEVICE_ADDRESS;
        cmd_register <= table_data[15:8];
        cmd_data     <= table_data[7:0];
      end
    end
  end

endmodule
